// File: rtl/axi_ram_wrap.sv
// AXI4 slave RAM with independent read and write engines.
// Handles FIXED/INCR/WRAP bursts, range (DECERR) and burst-legality (SLVERR) checks, and an optional R output register.
module axi_ram_wrap #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 16,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int ID_WIDTH        = 8,
    parameter int MEM_DEPTH       = 4096,
    parameter int PIPELINE_OUTPUT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);
    localparam int         SB          = $clog2(STRB_WIDTH);
    localparam int         MEM_AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [2:0] MAX_SIZE    = 3'(SB);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic is_illegal(input logic [1:0] burst, input logic [7:0] len);
        return (burst == BURST_RSVD) ||
               ((burst == BURST_WRAP) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    endfunction

    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        return (size > MAX_SIZE) ? MAX_SIZE : size;
    endfunction

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a >> SB) >= 32'(MEM_DEPTH);
    endfunction

    function automatic logic [MEM_AW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] w;
        w = a >> SB;
        return w[MEM_AW-1:0];
    endfunction

    // Illegal bursts step as INCR; the WRAP mask spans the whole (len+1)*S window.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [7:0] len, input logic [2:0] size,
                                                        input logic [1:0] burst, input logic ill);
        logic [ADDR_WIDTH-1:0] step, mask, res;
        step = ADDR_WIDTH'(1) << size;
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        if (burst == BURST_FIXED)
            res = a;
        else if ((burst == BURST_WRAP) && !ill)
            res = (a & ~mask) | ((a + step) & mask);
        else
            res = (a & ~(step - ADDR_WIDTH'(1))) + step;
        return res;
    endfunction

    logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

    // ---------------- write engine ----------------
    typedef enum logic [1:0] {W_IDLE, W_BURST, W_RESP} w_state_t;
    w_state_t              w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   w_id_q;
    logic [ADDR_WIDTH-1:0] w_addr_q;
    logic [7:0]            w_len_q, w_cnt_q;
    logic [2:0]            w_size_q;
    logic [1:0]            w_burst_q;
    logic                  w_ill_q, w_dec_q;
    logic                  awready_q, wready_q, bvalid_q;
    logic [ID_WIDTH-1:0]   bid_q;
    logic [1:0]            bresp_q;
    logic                  aw_hs, w_hs, w_last, w_oor, b_free, w_dec_acc, b_issue;

    assign aw_hs     = s_axi_awvalid && awready_q;
    assign w_hs      = s_axi_wvalid && wready_q;
    assign w_last    = (w_cnt_q == w_len_q);
    assign w_oor     = out_of_range(w_addr_q);
    assign b_free    = !bvalid_q || s_axi_bready;
    assign w_dec_acc = w_dec_q || (w_hs && w_oor);

    always_comb begin
        w_state_d = w_state_q;
        b_issue   = 1'b0;
        case (w_state_q)
            W_IDLE:  if (aw_hs) w_state_d = W_BURST;
            W_BURST: if (w_hs && w_last) begin
                if (b_free) begin
                    b_issue   = 1'b1;
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP:  if (b_free) begin
                b_issue   = 1'b1;
                w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_ill_q   <= 1'b0;
            w_dec_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= (w_state_d == W_IDLE);
            wready_q  <= (w_state_d == W_BURST);
            if (aw_hs) begin
                w_id_q    <= s_axi_awid;
                w_addr_q  <= s_axi_awaddr;
                w_len_q   <= s_axi_awlen;
                w_size_q  <= clamp_size(s_axi_awsize);
                w_burst_q <= s_axi_awburst;
                w_ill_q   <= is_illegal(s_axi_awburst, s_axi_awlen);
                w_cnt_q   <= '0;
                w_dec_q   <= 1'b0;
            end
            if (w_hs) begin
                w_addr_q <= next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q, w_ill_q);
                w_cnt_q  <= w_cnt_q + 8'd1;
                w_dec_q  <= w_dec_acc;
            end
            if (b_issue) begin
                bvalid_q <= 1'b1;
                bid_q    <= w_id_q;
                bresp_q  <= w_dec_acc ? RESP_DECERR : (w_ill_q ? RESP_SLVERR : RESP_OKAY);
            end else if (s_axi_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Memory is deliberately outside the reset domain so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (rst_n && w_hs && !w_ill_q && !w_oor) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (s_axi_wstrb[i]) mem[word_idx(w_addr_q)][8*i +: 8] <= s_axi_wdata[8*i +: 8];
            end
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bid     = bid_q;
    assign s_axi_bresp   = bresp_q;

    // ---------------- read engine ----------------
    typedef enum logic {R_IDLE, R_BURST} r_state_t;
    r_state_t              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   r_id_q;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [7:0]            r_len_q, r_cnt_q;
    logic [2:0]            r_size_q;
    logic [1:0]            r_burst_q;
    logic                  r_ill_q, arready_q;
    logic                  s1_v_q, s1_last_q, s1_adv, s1_ready;
    logic [ID_WIDTH-1:0]   s1_id_q;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic [1:0]            s1_resp_q;
    logic                  ar_hs, r_issue, r_last, r_oor;

    assign ar_hs    = s_axi_arvalid && arready_q;
    assign r_last   = (r_cnt_q == r_len_q);
    assign r_oor    = out_of_range(r_addr_q);
    assign s1_ready = !s1_v_q || s1_adv;
    assign r_issue  = (r_state_q == R_BURST) && s1_ready;

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_BURST;
            R_BURST: if (r_issue && r_last) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_ill_q   <= 1'b0;
            s1_v_q    <= 1'b0;
            s1_last_q <= 1'b0;
            s1_id_q   <= '0;
            s1_data_q <= '0;
            s1_resp_q <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= (r_state_d == R_IDLE);
            if (ar_hs) begin
                r_id_q    <= s_axi_arid;
                r_addr_q  <= s_axi_araddr;
                r_len_q   <= s_axi_arlen;
                r_size_q  <= clamp_size(s_axi_arsize);
                r_burst_q <= s_axi_arburst;
                r_ill_q   <= is_illegal(s_axi_arburst, s_axi_arlen);
                r_cnt_q   <= '0;
            end
            if (r_issue) begin
                s1_v_q    <= 1'b1;
                s1_id_q   <= r_id_q;
                s1_last_q <= r_last;
                s1_data_q <= r_oor ? '0 : mem[word_idx(r_addr_q)];
                s1_resp_q <= r_oor ? RESP_DECERR : (r_ill_q ? RESP_SLVERR : RESP_OKAY);
                r_addr_q  <= next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q, r_ill_q);
                r_cnt_q   <= r_cnt_q + 8'd1;
            end else if (s1_adv) begin
                s1_v_q <= 1'b0;
            end
        end
    end

    assign s_axi_arready = arready_q;

    generate
        if (PIPELINE_OUTPUT != 0) begin : g_pipe
            logic                  o_v_q, o_last_q;
            logic [ID_WIDTH-1:0]   o_id_q;
            logic [DATA_WIDTH-1:0] o_data_q;
            logic [1:0]            o_resp_q;

            assign s1_adv = s1_v_q && (!o_v_q || s_axi_rready);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    o_v_q    <= 1'b0;
                    o_last_q <= 1'b0;
                    o_id_q   <= '0;
                    o_data_q <= '0;
                    o_resp_q <= '0;
                end else if (s1_adv) begin
                    o_v_q    <= 1'b1;
                    o_last_q <= s1_last_q;
                    o_id_q   <= s1_id_q;
                    o_data_q <= s1_data_q;
                    o_resp_q <= s1_resp_q;
                end else if (s_axi_rready) begin
                    o_v_q <= 1'b0;
                end
            end

            assign s_axi_rvalid = o_v_q;
            assign s_axi_rlast  = o_last_q;
            assign s_axi_rid    = o_id_q;
            assign s_axi_rdata  = o_data_q;
            assign s_axi_rresp  = o_resp_q;
        end else begin : g_direct
            assign s1_adv       = s1_v_q && s_axi_rready;
            assign s_axi_rvalid = s1_v_q;
            assign s_axi_rlast  = s1_last_q;
            assign s_axi_rid    = s1_id_q;
            assign s_axi_rdata  = s1_data_q;
            assign s_axi_rresp  = s1_resp_q;
        end
    endgenerate

endmodule
